// File: rtl/mips_pkg.sv
// Shared processor constants for the register file and its write-back scoreboard.
package mips_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;
endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Read, write-back and issue signals of the register file scoreboard.
// Issue handshake: in_issue_en acts as valid and !out_stall as ready; an issue is
// accepted only on a rising edge where both hold, otherwise the issuer must hold.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
);
  localparam int REGS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] in_rd_addr_0;
  logic [ADDR_W-1:0] in_rd_addr_1;
  logic [DATA_W-1:0] out_rd_data_0;
  logic [DATA_W-1:0] out_rd_data_1;
  logic              in_wr_en;
  logic [ADDR_W-1:0] in_wr_addr;
  logic [DATA_W-1:0] in_wr_data;
  logic              in_issue_en;
  logic [ADDR_W-1:0] in_issue_addr;
  logic              out_stall;
  logic              out_busy_any;
  logic [REGS-1:0]   out_dbg_busy;

  modport slave (
    input  in_rd_addr_0, in_rd_addr_1, in_wr_en, in_wr_addr, in_wr_data,
    input  in_issue_en, in_issue_addr,
    output out_rd_data_0, out_rd_data_1, out_stall, out_busy_any, out_dbg_busy
  );

  modport master (
    output in_rd_addr_0, in_rd_addr_1, in_wr_en, in_wr_addr, in_wr_data,
    output in_issue_en, in_issue_addr,
    input  out_rd_data_0, out_rd_data_1, out_stall, out_busy_any, out_dbg_busy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one busy bit per register, set on accepted issue,
// cleared on write-back, and the operand-hazard stall derived from it.
module reg_scoreboard #(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADDR_W-1:0]    rd_addr_0_i,
  input  logic [ADDR_W-1:0]    rd_addr_1_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic                 issue_en_i,
  input  logic [ADDR_W-1:0]    issue_addr_i,
  output logic                 stall_o,
  output logic                 busy_any_o,
  output logic [2**ADDR_W-1:0] busy_o
);
  localparam int REGS = 2 ** ADDR_W;

  logic [REGS-1:0] busy_q;
  logic [REGS-1:0] busy_d;
  logic            hazard_0;
  logic            hazard_1;

  // A write-back landing this cycle resolves the hazard, since its data is bypassed.
  always_comb begin
    hazard_0 = (rd_addr_0_i != '0) && busy_q[rd_addr_0_i] &&
               !(wr_en_i && (wr_addr_i == rd_addr_0_i));
    hazard_1 = (rd_addr_1_i != '0) && busy_q[rd_addr_1_i] &&
               !(wr_en_i && (wr_addr_i == rd_addr_1_i));
    stall_o  = hazard_0 || hazard_1;
  end

  // Clear is applied first so a same-address issue overrides it.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (issue_en_i && !stall_o && (issue_addr_i != '0)) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_any_o = |busy_q;
  assign busy_o     = busy_q;
endmodule

// File: rtl/reg_file_scoreboard.sv
// Two-read/one-write register file with write-back bypass; pending-write
// tracking and stall generation live in reg_scoreboard.
module reg_file_scoreboard #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input logic                   in_clk,
  input logic                   in_rst_n,
  reg_file_scoreboard_if.slave  bus
);
  localparam int REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [REGS];
  logic [DATA_W-1:0] regs_d [REGS];
  logic              bypass_0;
  logic              bypass_1;

  always_comb begin
    regs_d = regs_q;
    if (bus.in_wr_en && (bus.in_wr_addr != '0)) begin
      regs_d[bus.in_wr_addr] = bus.in_wr_data;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads are forced to zero while reset is held so a write cannot bypass through.
  always_comb begin
    bypass_0 = bus.in_wr_en && (bus.in_wr_addr == bus.in_rd_addr_0);
    bypass_1 = bus.in_wr_en && (bus.in_wr_addr == bus.in_rd_addr_1);
    bus.out_rd_data_0 = '0;
    bus.out_rd_data_1 = '0;
    if (in_rst_n && (bus.in_rd_addr_0 != '0)) begin
      bus.out_rd_data_0 = bypass_0 ? bus.in_wr_data : regs_q[bus.in_rd_addr_0];
    end
    if (in_rst_n && (bus.in_rd_addr_1 != '0)) begin
      bus.out_rd_data_1 = bypass_1 ? bus.in_wr_data : regs_q[bus.in_rd_addr_1];
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i        (in_clk),
    .rst_ni       (in_rst_n),
    .rd_addr_0_i  (bus.in_rd_addr_0),
    .rd_addr_1_i  (bus.in_rd_addr_1),
    .wr_en_i      (bus.in_wr_en),
    .wr_addr_i    (bus.in_wr_addr),
    .issue_en_i   (bus.in_issue_en),
    .issue_addr_i (bus.in_issue_addr),
    .stall_o      (bus.out_stall),
    .busy_any_o   (bus.out_busy_any),
    .busy_o       (bus.out_dbg_busy)
  );
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for the register file scoreboard: storage, bypass, busy tracking, reset.
module tb_reg_file_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic in_clk;
  logic in_rst_n;
  int   checks;
  int   errors;

  reg_file_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_scoreboard #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .bus      (bus)
  );

  // Clock / reset
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.in_wr_en      = 1'b0;
    bus.in_wr_addr    = '0;
    bus.in_wr_data    = '0;
    bus.in_issue_en   = 1'b0;
    bus.in_issue_addr = '0;
  endtask

  task automatic drive_write(input logic [4:0] addr, input logic [31:0] data);
    bus.in_wr_en   = 1'b1;
    bus.in_wr_addr = addr;
    bus.in_wr_data = data;
  endtask

  task automatic drive_issue(input logic [4:0] addr);
    bus.in_issue_en   = 1'b1;
    bus.in_issue_addr = addr;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_rst_n = 1'b0;
    drive_idle();
    bus.in_rd_addr_0 = '0;
    bus.in_rd_addr_1 = '0;
    #1;
    check("reset_rd0", bus.out_rd_data_0, 32'h0);
    check("reset_stall", {31'b0, bus.out_stall}, 32'h0);
    check("reset_busy_any", {31'b0, bus.out_busy_any}, 32'h0);
    #11 in_rst_n = 1'b1;
    step();

    // Write then read back
    drive_write(5'd5, 32'hDEADBEEF);
    step();
    drive_idle();
    bus.in_rd_addr_0 = 5'd5;
    #1 check("rd_reg5", bus.out_rd_data_0, 32'hDEADBEEF);

    // Register 0 is hardwired
    drive_write(5'd0, 32'hFFFFFFFF);
    bus.in_rd_addr_0 = 5'd0;
    bus.in_rd_addr_1 = 5'd0;
    #1;
    check("r0_bypass_p0", bus.out_rd_data_0, 32'h0);
    check("r0_bypass_p1", bus.out_rd_data_1, 32'h0);
    step();
    drive_idle();
    drive_issue(5'd0);
    #1 check("r0_after_wr", bus.out_rd_data_0, 32'h0);
    step();
    drive_idle();
    check("r0_issue_busy_any", {31'b0, bus.out_busy_any}, 32'h0);

    // Same-cycle bypass
    drive_write(5'd7, 32'h12345678);
    bus.in_rd_addr_1 = 5'd7;
    #1 check("bypass_p1", bus.out_rd_data_1, 32'h12345678);
    step();
    drive_idle();
    bus.in_rd_addr_0 = 5'd5;
    #1;
    check("stored_r7", bus.out_rd_data_1, 32'h12345678);
    check("stored_r5", bus.out_rd_data_0, 32'hDEADBEEF);

    // Issue, stall, resolve via write-back
    bus.in_rd_addr_0 = 5'd0;
    bus.in_rd_addr_1 = 5'd0;
    drive_issue(5'd9);
    step();
    drive_idle();
    bus.in_rd_addr_0 = 5'd9;
    #1;
    check("stall_r9", {31'b0, bus.out_stall}, 32'h1);
    check("busy_any_r9", {31'b0, bus.out_busy_any}, 32'h1);
    check("busy_vec_r9", bus.out_dbg_busy, 32'h0000_0200);
    drive_write(5'd9, 32'h0000_0099);
    #1;
    check("stall_resolved", {31'b0, bus.out_stall}, 32'h0);
    check("bypass_r9", bus.out_rd_data_0, 32'h0000_0099);
    step();
    drive_idle();
    #1;
    check("busy_any_cleared", {31'b0, bus.out_busy_any}, 32'h0);
    check("stall_after_clear", {31'b0, bus.out_stall}, 32'h0);
    check("stored_r9", bus.out_rd_data_0, 32'h0000_0099);

    // Issue ignored while stalled; same-edge issue and write keeps busy set
    bus.in_rd_addr_0 = 5'd0;
    drive_issue(5'd3);
    step();
    drive_idle();
    bus.in_rd_addr_1 = 5'd3;
    #1 check("stall_r3", {31'b0, bus.out_stall}, 32'h1);
    drive_issue(5'd4);
    step();
    drive_idle();
    check("stalled_issue_dropped", bus.out_dbg_busy, 32'h0000_0008);
    check("stall_r3_held", {31'b0, bus.out_stall}, 32'h1);
    bus.in_rd_addr_1 = 5'd0;
    drive_issue(5'd6);
    drive_write(5'd6, 32'h0000_0066);
    #1 check("no_stall_before_set", {31'b0, bus.out_stall}, 32'h0);
    step();
    drive_idle();
    bus.in_rd_addr_0 = 5'd6;
    #1;
    check("set_wins", bus.out_dbg_busy, 32'h0000_0048);
    check("data_still_written", bus.out_rd_data_0, 32'h0000_0066);
    check("stall_r6", {31'b0, bus.out_stall}, 32'h1);

    // Asynchronous reset mid-operation
    bus.in_rd_addr_0 = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      drive_write(5'(i), 32'(i * 32'h11));
      step();
    end
    drive_idle();
    drive_issue(5'd2);
    step();
    drive_idle();
    bus.in_rd_addr_0 = 5'd2;
    bus.in_rd_addr_1 = 5'd4;
    #1;
    check("pre_rst_r2", bus.out_rd_data_0, 32'h0000_0022);
    check("pre_rst_r4", bus.out_rd_data_1, 32'h0000_0044);
    check("pre_rst_busy_any", {31'b0, bus.out_busy_any}, 32'h1);
    #1 in_rst_n = 1'b0;
    #1;
    check("rst_rd0", bus.out_rd_data_0, 32'h0);
    check("rst_rd1", bus.out_rd_data_1, 32'h0);
    check("rst_busy_any", {31'b0, bus.out_busy_any}, 32'h0);
    check("rst_stall", {31'b0, bus.out_stall}, 32'h0);
    check("rst_busy_vec", bus.out_dbg_busy, 32'h0);
    drive_write(5'd1, 32'hCAFE_F00D);
    bus.in_rd_addr_0 = 5'd1;
    #1 check("rst_no_bypass", bus.out_rd_data_0, 32'h0);
    drive_idle();
    #1 in_rst_n = 1'b1;
    #1;
    check("post_rst_r1", bus.out_rd_data_0, 32'h0);
    check("post_rst_r4", bus.out_rd_data_1, 32'h0);
    drive_write(5'd1, 32'h0000_00AB);
    step();
    drive_idle();
    #1 check("first_edge_write", bus.out_rd_data_0, 32'h0000_00AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
